// File: rtl/booth_seq_mul.sv
// Sequential radix-4 modified-Booth multiplier for unsigned operands.
// One Booth digit is consumed per cycle, WIDTH/2+1 cycles per product,
// with valid/ready handshakes on both the operand and the result side.

// Radix-4 Booth digit encoder for a 3-bit overlapping multiplier window.
module boothEnc (
  input  logic [2:0] window,
  output logic       sel_single,
  output logic       sel_double,
  output logic       neg
);
  // Digit values: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
  // For 111, neg is set but both magnitude selects are low, so the term is zero.
  assign sel_single = window[0] ^ window[1];
  assign sel_double = (window == 3'b011) || (window == 3'b100);
  assign neg        = window[2];
endmodule

module booth_seq_mul #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int N     = WIDTH / 2 + 1;
  // Two guard bits keep the signed running sum exact; the final value is
  // always non-negative and fits in 2*WIDTH bits.
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  // Multiplicand pre-shifted by 2*i, so no barrel shifter is needed.
  logic [ACC_W-1:0]   mcand_reg;
  // Multiplier, zero-extended by two MSBs and shifted right two bits per digit.
  logic [WIDTH+1:0]   mult_reg;
  // Bit b[2i-1] of the current window (b[-1] = 0 at the first digit).
  logic               prev_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic [2:0]         window;
  logic               sel_single, sel_double, neg;
  logic [ACC_W-1:0]   mag;
  logic [ACC_W-1:0]   pp;
  logic [ACC_W-1:0]   acc_sum;
  logic               last_iter;

  assign window = {mult_reg[1:0], prev_reg};

  boothEnc u_enc (
    .window     (window),
    .sel_single (sel_single),
    .sel_double (sel_double),
    .neg        (neg)
  );

  // Select, optionally negate and accumulate the current partial product.
  always_comb begin
    mag = '0;
    if (sel_single) begin
      mag = mcand_reg;
    end else if (sel_double) begin
      mag = mcand_reg << 1;
    end
    pp      = neg ? (~mag + {{(ACC_W-1){1'b0}}, 1'b1}) : mag;
    acc_sum = acc_reg + pp;
  end

  assign last_iter = (cnt_reg == CNT_W'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, N digit cycles in RUN, hold in DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs come from state only.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign product   = product_reg;

  // Datapath: capture operands on accept, step one Booth digit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg   <= '0;
      mult_reg    <= '0;
      prev_reg    <= 1'b0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg <= {{(ACC_W-WIDTH){1'b0}}, a};
            mult_reg  <= {2'b00, b};
            prev_reg  <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          acc_reg   <= acc_sum;
          mcand_reg <= mcand_reg << 2;
          mult_reg  <= mult_reg >> 2;
          prev_reg  <= mult_reg[1];
          cnt_reg   <= cnt_reg + CNT_W'(1);
          if (last_iter) begin
            product_reg <= acc_sum[2*WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed and randomised checks of booth_seq_mul at WIDTH=24.
module tb_booth_seq_mul;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;

  int compared   = 0;
  int mismatched = 0;

  booth_seq_mul #(.WIDTH(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one operand pair for one edge.
  task automatic accept(input logic [23:0] x, input logic [23:0] y);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    check("accept_ready", in_ready, 1'b1);
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 24'($urandom);
    b = 24'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction: accept, latency/product check, optional stall, handshake.
  task automatic do_txn(input string tag, input logic [23:0] x, input logic [23:0] y,
                        input logic [47:0] expected, input int stall);
    int lat;
    accept(x, y);
    wait_valid(lat);
    check({tag, "_latency"}, 48'(lat), 48'd13);
    check({tag, "_product"}, product, expected);
    for (int s = 0; s < stall; s++) tick();
    if (stall > 0) check({tag, "_stall_valid"}, out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    logic [23:0] ra, rb;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_product", product, 48'd0);

    // Directed products.
    do_txn("basic", 24'd3, 24'd5, 48'd15, 0);
    do_txn("max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 0);
    do_txn("zero_a", 24'h000000, 24'hFFFFFF, 48'h0, 1);
    do_txn("alt_aa", 24'hFFFFFF, 24'hAAAAAA, 48'hAAAAA9555556, 0);
    do_txn("alt_55", 24'h800000, 24'h555555, 48'h2AAAAA800000, 2);
    do_txn("one_x_max", 24'd1, 24'hFFFFFF, 48'hFFFFFF, 0);

    // Backpressure with input activity while DONE is held.
    accept(24'h001000, 24'h001000);
    wait_valid(lat);
    check("bp_latency", 48'(lat), 48'd13);
    for (int c = 0; c < 20; c++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      in_valid = (c % 2 == 0);
      tick();
      check("bp_product", product, 48'h000001000000);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_release_out_valid", out_valid, 1'b0);

    // Reset in the middle of RUN, sampled at the edge of digit iteration 6.
    accept(24'hFFFFFF, 24'hFFFFFF);
    for (int c = 0; c < 6; c++) tick();
    check("mid_running", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_product", product, 48'd0);
    do_txn("after_rst", 24'd7, 24'd9, 48'd63, 0);

    // Random back-to-back traffic against a bench-side a*b reference.
    for (int t = 0; t < 1000; t++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      if (t % 7 == 0) ra = 24'hFFFFFF;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      do_txn("rand", ra, rb, 48'(ra) * 48'(rb), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
